io_bus_master: RTL and testbench

Z80-style I/O bus initiator for the executor's CPU-side register file. It turns a simple command handshake (write/read one 8-bit port) into correctly sequenced io_req/rd/wr bus cycles. It also runs interrupt-acknowledge (M1+IORQ) cycles to fetch the vector, and reports NMI events. Used as a CPU replacement in test fixtures and for host-bridge access to the executor registers.

---
 rtl/io_bus_master_if.sv | 35 +++
 rtl/io_bus_master.sv | 204 ++++++++++++++++++++
 tb/tb_io_bus_master.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/io_bus_master_if.sv
`default_nettype none
// ============================================================================
// Module   : io_bus_master_if
// Purpose  : Command/response handshake between a host (command source) and
//            the io_bus_master Z80-style I/O initiator.
// Signals  : cmd_valid/cmd_ready/cmd_wr/cmd_adr/cmd_wdata  command request
//            rsp_valid/rsp_rdata                           command completion
//            irq_valid/irq_vector                          INTA completion
//            nmi_evt                                       NMI falling-edge event
// Modports : master = command source, slave = io_bus_master
// Revision : 1.0  initial release
// ============================================================================
interface io_bus_master_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_wr;
  logic [7:0] cmd_adr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       irq_valid;
  logic [7:0] irq_vector;
  logic       nmi_evt;

  modport master (
    output cmd_valid, cmd_wr, cmd_adr, cmd_wdata,
    input  cmd_ready, rsp_valid, rsp_rdata, irq_valid, irq_vector, nmi_evt
  );

  modport slave (
    input  cmd_valid, cmd_wr, cmd_adr, cmd_wdata,
    output cmd_ready, rsp_valid, rsp_rdata, irq_valid, irq_vector, nmi_evt
  );
endinterface
`default_nettype wire

// File: rtl/io_bus_master.sv
`default_nettype none
// ============================================================================
// Module   : io_bus_master
// Purpose  : Z80-style I/O bus initiator. Turns single-port read/write
//            commands into io_req/rd/wr bus cycles, runs interrupt-acknowledge
//            (M1+IORQ) cycles to fetch a vector, and reports NMI falling edges.
// Ports    : clk_cpu, reset    clock, asynchronous active-high reset
//            host              command/response interface (slave modport)
//            a_cpu             address bus
//            d_cpu             bidirectional data bus, driven only for writes
//            io_req_cpu, rd_cpu, wr_cpu, m1_cpu   active-low bus strobes
//            int_cpu, nmi_cpu  active-low open-drain interrupt inputs
// Params   : STROBE_CYCLES     strobe width in clk_cpu cycles (1..15)
//            INT_ACK_EN        1 = service int_cpu with INTA cycles
// Revision : 1.0  initial release
// ============================================================================
module io_bus_master #(
  parameter int unsigned STROBE_CYCLES = 2,
  parameter bit          INT_ACK_EN    = 1'b1
) (
  input  wire logic       clk_cpu,
  input  wire logic       reset,
  io_bus_master_if.slave  host,
  output logic [7:0]      a_cpu,
  inout  wire  [7:0]      d_cpu,
  output logic            io_req_cpu,
  output logic            rd_cpu,
  output logic            wr_cpu,
  output logic            m1_cpu,
  input  wire logic       int_cpu,
  input  wire logic       nmi_cpu
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_STROBE = 2'd2,
    S_HOLD   = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    OP_WR   = 2'd0,
    OP_RD   = 2'd1,
    OP_INTA = 2'd2
  } op_t;

  localparam logic [3:0] STROBE_LAST = 4'(STROBE_CYCLES - 1);

  state_t     state;
  state_t     state_nxt;
  op_t        op;
  logic [3:0] strobe_cnt;
  logic [7:0] wdata;
  logic [7:0] rsp_rdata;
  logic [7:0] irq_vector;

  logic       int_meta;
  logic       int_sync;
  logic       int_armed;
  logic       nmi_meta;
  logic       nmi_sync;
  logic       nmi_prev;
  logic       nmi_evt;

  logic       inta_due;
  logic       cmd_ready;
  logic       strobe_last;

  // --------------------------------------------------------------------------
  // Input synchronisers. The lines are open-drain with external pull-ups, so
  // anything other than a solid 0 (including z) reads as the inactive 1.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_cpu or posedge reset) begin
    if (reset) begin
      int_meta <= 1'b1;
      int_sync <= 1'b1;
      nmi_meta <= 1'b1;
      nmi_sync <= 1'b1;
      nmi_prev <= 1'b1;
      nmi_evt  <= 1'b0;
    end else begin
      int_meta <= (int_cpu !== 1'b0);
      int_sync <= int_meta;
      nmi_meta <= (nmi_cpu !== 1'b0);
      nmi_sync <= nmi_meta;
      nmi_prev <= nmi_sync;
      nmi_evt  <= nmi_prev & ~nmi_sync;
    end
  end

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_cpu or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next state and bus strobes. Strobes decode straight from the state so an
  // asynchronous reset returns them high immediately.
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt   = state;
    inta_due    = 1'b0;
    cmd_ready   = 1'b0;
    strobe_last = (strobe_cnt == STROBE_LAST);
    io_req_cpu  = 1'b1;
    rd_cpu      = 1'b1;
    wr_cpu      = 1'b1;
    m1_cpu      = 1'b1;

    case (state)
      S_IDLE: begin
        // A pending acknowledge takes the bus ahead of any host command.
        inta_due  = INT_ACK_EN && !int_sync && int_armed;
        cmd_ready = !inta_due && !reset;
        if (inta_due || (host.cmd_valid && cmd_ready)) begin
          state_nxt = S_SETUP;
        end
      end
      S_SETUP: begin
        state_nxt = S_STROBE;
      end
      S_STROBE: begin
        io_req_cpu = 1'b0;
        case (op)
          OP_WR:   wr_cpu = 1'b0;
          OP_RD:   rd_cpu = 1'b0;
          default: m1_cpu = 1'b0;
        endcase
        if (strobe_last) begin
          state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: command latch, strobe counter, INTA arming, data capture.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_cpu or posedge reset) begin
    if (reset) begin
      op         <= OP_RD;
      a_cpu      <= 8'h00;
      wdata      <= 8'h00;
      strobe_cnt <= 4'd0;
      int_armed  <= 1'b1;
      rsp_rdata  <= 8'h00;
      irq_vector <= 8'h00;
    end else begin
      // One INTA per low level: re-arm only once the line is seen released.
      if (int_sync) begin
        int_armed <= 1'b1;
      end

      if (state == S_IDLE) begin
        if (inta_due) begin
          op        <= OP_INTA;
          a_cpu     <= 8'h00;
          int_armed <= 1'b0;
        end else if (host.cmd_valid && cmd_ready) begin
          op    <= host.cmd_wr ? OP_WR : OP_RD;
          a_cpu <= host.cmd_adr;
          wdata <= host.cmd_wdata;
        end
      end

      if (state == S_STROBE) begin
        if (strobe_last) begin
          strobe_cnt <= 4'd0;
          if (op == OP_RD) begin
            rsp_rdata <= d_cpu;
          end else if (op == OP_INTA) begin
            irq_vector <= d_cpu;
          end
        end else begin
          strobe_cnt <= strobe_cnt + 4'd1;
        end
      end
    end
  end

  // Write data is on the bus from SETUP through HOLD only.
  assign d_cpu = (op == OP_WR && state != S_IDLE) ? wdata : 8'hzz;

  assign host.cmd_ready  = cmd_ready;
  assign host.rsp_valid  = (state == S_HOLD) && (op != OP_INTA);
  assign host.irq_valid  = (state == S_HOLD) && (op == OP_INTA);
  assign host.rsp_rdata  = rsp_rdata;
  assign host.irq_vector = irq_vector;
  assign host.nmi_evt    = nmi_evt;

endmodule
`default_nettype wire

// File: tb/tb_io_bus_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_io_bus_master
// Purpose  : Directed self-checking bench for io_bus_master (STROBE_CYCLES=2,
//            INT_ACK_EN=1). A device model answers reads/INTA on d_cpu and a
//            keeper value (0xC3) occupies the bus whenever nobody else should.
// Revision : 1.0  initial release
// ============================================================================
module tb_io_bus_master;

  logic clk_cpu;
  logic reset;
  logic int_cpu;
  logic nmi_cpu;
  wire  [7:0] d_cpu;
  logic [7:0] a_cpu;
  logic io_req_cpu;
  logic rd_cpu;
  logic wr_cpu;
  logic m1_cpu;

  io_bus_master_if host ();

  io_bus_master #(
    .STROBE_CYCLES (2),
    .INT_ACK_EN    (1'b1)
  ) dut (
    .clk_cpu    (clk_cpu),
    .reset      (reset),
    .host       (host),
    .a_cpu      (a_cpu),
    .d_cpu      (d_cpu),
    .io_req_cpu (io_req_cpu),
    .rd_cpu     (rd_cpu),
    .wr_cpu     (wr_cpu),
    .m1_cpu     (m1_cpu),
    .int_cpu    (int_cpu),
    .nmi_cpu    (nmi_cpu)
  );

  localparam logic [7:0] KEEP = 8'hC3;

  // Device model and bus keeper
  logic [7:0] dev_rdata;
  logic [7:0] dev_vec;
  logic       dut_may_drive;
  wire        dev_drive = !io_req_cpu && (!rd_cpu || !m1_cpu);
  wire        keep_drive = !dut_may_drive && !dev_drive;

  assign d_cpu = dev_drive  ? (!m1_cpu ? dev_vec : dev_rdata) : 8'hzz;
  assign d_cpu = keep_drive ? KEEP : 8'hzz;

  int n_checks;
  int n_errors;

  initial clk_cpu = 1'b0;
  always #5 clk_cpu = ~clk_cpu;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_cpu);
    #1;
  endtask

  // Strobes packed as {io_req, rd, wr, m1}
  function automatic logic [3:0] strobes();
    return {io_req_cpu, rd_cpu, wr_cpu, m1_cpu};
  endfunction

  // Full command cycle starting in IDLE; rdat is the device read value for a
  // read, or the value rsp_rdata must still hold for a write.
  task automatic do_cmd(input bit wr, input logic [7:0] adr, input logic [7:0] wdat,
                        input logic [7:0] rdat);
    logic [3:0] exp_strobe;
    exp_strobe = wr ? 4'b0101 : 4'b0011;
    dev_rdata       = rdat;
    dut_may_drive   = wr;
    host.cmd_valid  = 1'b1;
    host.cmd_wr     = wr;
    host.cmd_adr    = adr;
    host.cmd_wdata  = wdat;
    #1;
    check("c0_ready", host.cmd_ready, 1);
    tick();
    host.cmd_valid = 1'b0;
    check("c1_addr", a_cpu, adr);
    check("c1_strobes", strobes(), 4'hF);
    check("c1_data", d_cpu, wr ? wdat : KEEP);
    check("c1_ready", host.cmd_ready, 0);
    tick();
    check("c2_strobes", strobes(), exp_strobe);
    check("c2_data", d_cpu, wr ? wdat : rdat);
    tick();
    check("c3_strobes", strobes(), exp_strobe);
    check("c3_rsp", host.rsp_valid, 0);
    tick();
    check("c4_strobes", strobes(), 4'hF);
    check("c4_rsp", host.rsp_valid, 1);
    check("c4_rdata", host.rsp_rdata, rdat);
    check("c4_data", d_cpu, wr ? wdat : KEEP);
    check("c4_addr", a_cpu, adr);
    dut_may_drive = 1'b0;
    tick();
    check("c5_ready", host.cmd_ready, 1);
    check("c5_rsp", host.rsp_valid, 0);
    check("c5_data", d_cpu, KEEP);
    check("c5_addr", a_cpu, adr);
  endtask

  initial begin
    int m1_low;
    int irq_cnt;
    int nmi_cnt;
    int nmi_at;
    int rsp_cnt;

    n_checks       = 0;
    n_errors       = 0;
    reset          = 1'b1;
    int_cpu        = 1'b1;
    nmi_cpu        = 1'b1;
    dut_may_drive  = 1'b0;
    dev_rdata      = 8'h00;
    dev_vec        = 8'h00;
    host.cmd_valid = 1'b0;
    host.cmd_wr    = 1'b0;
    host.cmd_adr   = 8'h00;
    host.cmd_wdata = 8'h00;

    // Reset state, before any clock edge
    #2;
    check("rst_strobes", strobes(), 4'hF);
    check("rst_addr", a_cpu, 8'h00);
    check("rst_data", d_cpu, KEEP);
    check("rst_ready", host.cmd_ready, 0);
    check("rst_rsp", host.rsp_valid, 0);
    check("rst_irq", host.irq_valid, 0);
    check("rst_nmi", host.nmi_evt, 0);
    check("rst_rdata", host.rsp_rdata, 8'h00);
    check("rst_vec", host.irq_vector, 8'h00);
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Write, read, then write again with rsp_rdata held
    do_cmd(1'b1, 8'hA7, 8'h04, 8'h00);
    do_cmd(1'b0, 8'hA2, 8'h00, 8'h5A);
    do_cmd(1'b1, 8'h19, 8'hE7, 8'h5A);

    // INTA: int low at cycle c, due at c+2, HOLD at c+6
    dev_vec = 8'h22;
    int_cpu = 1'b0;
    tick();
    tick();
    check("inta_ready_low", host.cmd_ready, 0);
    tick();
    check("inta_setup_addr", a_cpu, 8'h00);
    check("inta_setup_strb", strobes(), 4'hF);
    tick();
    check("inta_strobes", strobes(), 4'b0110);
    tick();
    check("inta_strobes2", strobes(), 4'b0110);
    tick();
    check("inta_irq_valid", host.irq_valid, 1);
    check("inta_vector", host.irq_vector, 8'h22);
    check("inta_rsp_quiet", host.rsp_valid, 0);
    tick();
    check("inta_irq_end", host.irq_valid, 0);
    check("inta_not_rearmed", host.cmd_ready, 1);

    // Level stays low: no second INTA
    m1_low = 0;
    irq_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (!m1_cpu) m1_low++;
      if (host.irq_valid) irq_cnt++;
    end
    check("no_second_inta_m1", m1_low, 0);
    check("no_second_inta_irq", irq_cnt, 0);

    // Release and reassert: exactly one new INTA
    int_cpu = 1'b1;
    repeat (4) tick();
    dev_vec = 8'h35;
    int_cpu = 1'b0;
    m1_low = 0;
    irq_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!m1_cpu) m1_low++;
      if (host.irq_valid) irq_cnt++;
    end
    check("rearm_m1_cycles", m1_low, 2);
    check("rearm_irq_cnt", irq_cnt, 1);
    check("rearm_vector", host.irq_vector, 8'h35);

    // INTA and command pending together: INTA first, then the command
    int_cpu = 1'b1;
    repeat (4) tick();
    dev_vec   = 8'h41;
    dev_rdata = 8'h96;
    int_cpu   = 1'b0;
    tick();
    tick();
    host.cmd_valid = 1'b1;
    host.cmd_wr    = 1'b0;
    host.cmd_adr   = 8'h3B;
    #1;
    check("both_ready_low", host.cmd_ready, 0);
    repeat (4) tick();
    check("both_irq_first", host.irq_valid, 1);
    check("both_vector", host.irq_vector, 8'h41);
    tick();
    check("both_accept", host.cmd_ready, 1);
    tick();
    host.cmd_valid = 1'b0;
    check("both_addr", a_cpu, 8'h3B);
    repeat (3) tick();
    check("both_rsp", host.rsp_valid, 1);
    check("both_rdata", host.rsp_rdata, 8'h96);
    check("both_vec_held", host.irq_vector, 8'h41);
    int_cpu = 1'b1;
    repeat (4) tick();

    // NMI: one pulse, on the third edge after the fall
    nmi_cpu = 1'b0;
    nmi_cnt = 0;
    nmi_at  = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (host.nmi_evt) begin
        nmi_cnt++;
        nmi_at = i;
      end
    end
    check("nmi_count", nmi_cnt, 1);
    check("nmi_latency", nmi_at, 3);
    check("nmi_no_bus", strobes(), 4'hF);
    nmi_cpu = 1'b1;
    repeat (4) tick();

    // Reset during the strobe of a write
    dut_may_drive  = 1'b1;
    host.cmd_valid = 1'b1;
    host.cmd_wr    = 1'b1;
    host.cmd_adr   = 8'h5E;
    host.cmd_wdata = 8'h81;
    tick();
    host.cmd_valid = 1'b0;
    tick();
    check("abort_wr_low", strobes(), 4'b0101);
    #2;
    reset         = 1'b1;
    dut_may_drive = 1'b0;
    #1;
    check("abort_strobes", strobes(), 4'hF);
    check("abort_data", d_cpu, KEEP);
    check("abort_ready", host.cmd_ready, 0);
    check("abort_addr", a_cpu, 8'h00);
    rsp_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (host.rsp_valid) rsp_cnt++;
    end
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      if (host.rsp_valid) rsp_cnt++;
    end
    check("abort_no_rsp", rsp_cnt, 0);
    do_cmd(1'b1, 8'h12, 8'h6E, 8'h00);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
